cjg_call_ctrl: RTL and testbench

- Sequencer directly upstream of the hardware call stack (cjg_stack). Turns call/return/interrupt/return-from-interrupt requests from the control unit into push/pop/data strobes on the stack.
- Captures popped values and reloads PC and SR from them.
- Tracks stack occupancy; flags overflow and underflow with sticky bits.

---
 rtl/cjg_call_ctrl_if.sv | 40 ++++
 rtl/cjg_call_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cjg_call_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cjg_call_ctrl_if.sv
// rtl/cjg_call_ctrl_if.sv - control-unit and stack side signals of the call sequencer
interface cjg_call_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
);
    logic             call_req;
    logic             ret_req;
    logic             int_req;
    logic             reti_req;
    logic [WIDTH-1:0] pc_in;
    logic [WIDTH-1:0] sr_in;
    logic             err_clr;
    logic             ready;
    logic             done;
    logic             stack_push;
    logic             stack_pop;
    logic [WIDTH-1:0] stack_d;
    logic [WIDTH-1:0] stack_q;
    logic [WIDTH-1:0] pc_out;
    logic             pc_load;
    logic [WIDTH-1:0] sr_out;
    logic             sr_load;
    logic [CW-1:0]    depth;
    logic             overflow;
    logic             underflow;

    // Control unit and stack model side
    modport master (
        output call_req, ret_req, int_req, reti_req, pc_in, sr_in, err_clr, stack_q,
        input  ready, done, stack_push, stack_pop, stack_d, pc_out, pc_load,
               sr_out, sr_load, depth, overflow, underflow
    );

    // Sequencer side
    modport slave (
        input  call_req, ret_req, int_req, reti_req, pc_in, sr_in, err_clr, stack_q,
        output ready, done, stack_push, stack_pop, stack_d, pc_out, pc_load,
               sr_out, sr_load, depth, overflow, underflow
    );
endinterface

// File: rtl/cjg_call_ctrl.sv
// rtl/cjg_call_ctrl.sv - call/return/interrupt sequencer in front of the hardware call stack
module cjg_call_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic           clk,
    input  logic           reset,
    cjg_call_ctrl_if.slave bus,
    input  logic           scan_in0,
    input  logic           scan_en,
    input  logic           test_mode,
    output logic           scan_out0
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_PC,
        S_PUSH_SR,
        S_POP_SR,
        S_POP_PC
    } state_t;

    state_t           state;
    logic             op_int;
    logic [WIDTH-1:0] pc_cap;
    logic [WIDTH-1:0] sr_cap;
    logic [WIDTH-1:0] pc_out_r;
    logic [WIDTH-1:0] sr_out_r;
    logic             pc_load_r;
    logic             sr_load_r;
    logic             ready_r;
    logic [CW-1:0]    depth_r;
    logic             ovf_r;
    logic             unf_r;

    logic             push;
    logic             pop;
    logic             done_c;
    logic [WIDTH-1:0] d_c;
    logic             any_req;
    logic             at_full;
    logic             at_empty;

    // DFT hooks carry no function in RTL
    wire unused_dft = &{1'b0, scan_in0, scan_en, test_mode};
    assign scan_out0 = 1'b0;

    assign any_req  = bus.int_req | bus.reti_req | bus.call_req | bus.ret_req;
    assign at_full  = (depth_r == CW'(DEPTH));
    assign at_empty = (depth_r == '0);

    // Stack strobes and done decode straight from the current state
    always_comb begin
        push   = 1'b0;
        pop    = 1'b0;
        done_c = 1'b0;
        d_c    = '0;
        case (state)
            S_PUSH_PC: begin
                push   = 1'b1;
                d_c    = pc_cap;
                done_c = ~op_int;
            end
            S_PUSH_SR: begin
                push   = 1'b1;
                d_c    = sr_cap;
                done_c = 1'b1;
            end
            S_POP_SR: pop = 1'b1;
            S_POP_PC: begin
                pop    = 1'b1;
                done_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer FSM, reload capture, occupancy tracking and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_int    <= 1'b0;
            pc_cap    <= '0;
            sr_cap    <= '0;
            pc_out_r  <= '0;
            sr_out_r  <= '0;
            pc_load_r <= 1'b0;
            sr_load_r <= 1'b0;
            ready_r   <= 1'b0;
            depth_r   <= '0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else begin
            pc_load_r <= (state == S_POP_PC);
            sr_load_r <= (state == S_POP_SR);
            if (state == S_POP_PC) pc_out_r <= bus.stack_q;
            if (state == S_POP_SR) sr_out_r <= bus.stack_q;

            case (state)
                S_IDLE: begin
                    // ready is held low for the first cycle out of reset
                    ready_r <= 1'b1;
                    if (ready_r && any_req) begin
                        ready_r <= 1'b0;
                        pc_cap  <= bus.pc_in;
                        sr_cap  <= bus.sr_in;
                        if (bus.int_req) begin
                            op_int <= 1'b1;
                            state  <= S_PUSH_PC;
                        end else if (bus.reti_req) begin
                            state  <= S_POP_SR;
                        end else if (bus.call_req) begin
                            op_int <= 1'b0;
                            state  <= S_PUSH_PC;
                        end else begin
                            state  <= S_POP_PC;
                        end
                    end
                end
                S_PUSH_PC: begin
                    if (op_int) begin
                        state <= S_PUSH_SR;
                    end else begin
                        state   <= S_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                S_PUSH_SR: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                end
                S_POP_SR: state <= S_POP_PC;
                S_POP_PC: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                end
            endcase

            // Saturating occupancy; strobes still go out at the limits
            if (push && !at_full)
                depth_r <= depth_r + CW'(1);
            else if (pop && !at_empty)
                depth_r <= depth_r - CW'(1);

            // A new error in the same cycle as err_clr keeps the flag set
            ovf_r <= (ovf_r & ~bus.err_clr) | (push & at_full);
            unf_r <= (unf_r & ~bus.err_clr) | (pop & at_empty);
        end
    end

    assign bus.ready      = ready_r;
    assign bus.done       = done_c;
    assign bus.stack_push = push;
    assign bus.stack_pop  = pop;
    assign bus.stack_d    = d_c;
    assign bus.pc_out     = pc_out_r;
    assign bus.pc_load    = pc_load_r;
    assign bus.sr_out     = sr_out_r;
    assign bus.sr_load    = sr_load_r;
    assign bus.depth      = depth_r;
    assign bus.overflow   = ovf_r;
    assign bus.underflow  = unf_r;
endmodule

// File: tb/tb_cjg_call_ctrl.sv
// tb/tb_cjg_call_ctrl.sv - randomized self-checking bench for cjg_call_ctrl
module tb_cjg_call_ctrl;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int CW = 5;

    localparam logic [3:0] R_INT  = 4'b1000;
    localparam logic [3:0] R_RETI = 4'b0100;
    localparam logic [3:0] R_CALL = 4'b0010;
    localparam logic [3:0] R_RET  = 4'b0001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scan_in0 = 1'b0;
    logic scan_en = 1'b0;
    logic test_mode = 1'b0;
    logic scan_out0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cjg_call_ctrl_if #(.WIDTH(W), .CW(CW)) bus ();

    cjg_call_ctrl #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .scan_in0  (scan_in0),
        .scan_en   (scan_en),
        .test_mode (test_mode),
        .scan_out0 (scan_out0)
    );

    // Downstream stack: keeps the newest DEPTH entries, pops 0 when empty
    logic [W-1:0] env_mem [D];
    int           env_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            env_cnt <= 0;
        end else if (bus.stack_push) begin
            if (env_cnt == D) begin
                for (int i = 0; i < D - 1; i++) env_mem[i] <= env_mem[i+1];
                env_mem[D-1] <= bus.stack_d;
            end else begin
                env_mem[env_cnt] <= bus.stack_d;
                env_cnt <= env_cnt + 1;
            end
        end else if (bus.stack_pop && env_cnt > 0) begin
            env_cnt <= env_cnt - 1;
        end
    end

    assign bus.stack_q = (env_cnt > 0) ? env_mem[env_cnt-1] : '0;

    // Reference: call history as a LIFO of at most DEPTH values plus sticky flags
    logic [W-1:0] ref_stk [$];
    bit           ref_ovf;
    bit           ref_unf;

    function automatic void ref_push(input logic [W-1:0] v);
        if (ref_stk.size() == D) begin
            ref_ovf = 1'b1;
            void'(ref_stk.pop_front());
        end
        ref_stk.push_back(v);
    endfunction

    function automatic logic [W-1:0] ref_pop();
        if (ref_stk.size() == 0) begin
            ref_unf = 1'b1;
            return '0;
        end
        return ref_stk.pop_back();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_strobes(input string tag, input bit push, input bit pop,
                               input logic [W-1:0] d, input bit done);
        chk({tag, ".push"}, 32'(bus.stack_push), 32'(push));
        chk({tag, ".pop"},  32'(bus.stack_pop),  32'(pop));
        chk({tag, ".d"},    bus.stack_d, d);
        chk({tag, ".done"}, 32'(bus.done), 32'(done));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ready"}, 32'(bus.ready), 0);
        chk_strobes(tag, 0, 0, '0, 0);
        chk({tag, ".pc_out"},  bus.pc_out, 0);
        chk({tag, ".pc_load"}, 32'(bus.pc_load), 0);
        chk({tag, ".sr_out"},  bus.sr_out, 0);
        chk({tag, ".sr_load"}, 32'(bus.sr_load), 0);
        chk({tag, ".depth"},   32'(bus.depth), 0);
        chk({tag, ".ovf"},     32'(bus.overflow), 0);
        chk({tag, ".unf"},     32'(bus.underflow), 0);
        chk({tag, ".scan"},    32'(scan_out0), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", 32'(bus.ready), 1);
    endtask

    task automatic clr_err();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        ref_ovf = 1'b0;
        ref_unf = 1'b0;
        chk("clr.ovf", 32'(bus.overflow), 0);
        chk("clr.unf", 32'(bus.underflow), 0);
    endtask

    // Final-state housekeeping: optional err_clr overlapping the last step
    task automatic final_clr(input bit clr_fin);
        if (clr_fin) begin
            bus.err_clr = 1'b1;
            ref_ovf = 1'b0;
            ref_unf = 1'b0;
        end
    endtask

    // Issue one request set and check every cycle of the resulting sequence
    task automatic run_op(input logic [3:0] req, input logic [W-1:0] pc,
                          input logic [W-1:0] sr, input bit clr_fin);
        logic [W-1:0] exp_pc;
        logic [W-1:0] exp_sr;
        bit           pops_pc;
        wait_ready();
        {bus.int_req, bus.reti_req, bus.call_req, bus.ret_req} = req;
        bus.pc_in = pc;
        bus.sr_in = sr;
        @(posedge clk);
        @(negedge clk);
        {bus.int_req, bus.reti_req, bus.call_req, bus.ret_req} = 4'b0000;
        bus.pc_in = $urandom;
        bus.sr_in = $urandom;
        chk("busy.ready", 32'(bus.ready), 0);
        pops_pc = 1'b0;
        exp_pc  = '0;
        if (req[3]) begin
            chk_strobes("int1", 1, 0, pc, 0);
            ref_push(pc);
            bus.ret_req = 1'b1;
            @(negedge clk);
            bus.ret_req = 1'b0;
            final_clr(clr_fin);
            chk_strobes("int2", 1, 0, sr, 1);
            ref_push(sr);
        end else if (req[2]) begin
            chk_strobes("reti1", 0, 1, '0, 0);
            exp_sr = ref_pop();
            bus.call_req = 1'b1;
            @(negedge clk);
            bus.call_req = 1'b0;
            final_clr(clr_fin);
            chk_strobes("reti2", 0, 1, '0, 1);
            chk("reti.sr_load", 32'(bus.sr_load), 1);
            chk("reti.sr_out", bus.sr_out, exp_sr);
            exp_pc  = ref_pop();
            pops_pc = 1'b1;
        end else if (req[1]) begin
            final_clr(clr_fin);
            chk_strobes("call", 1, 0, pc, 1);
            ref_push(pc);
        end else begin
            final_clr(clr_fin);
            chk_strobes("ret", 0, 1, '0, 1);
            exp_pc  = ref_pop();
            pops_pc = 1'b1;
        end
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("end.ready", 32'(bus.ready), 1);
        chk_strobes("end", 0, 0, '0, 0);
        chk("end.pc_load", 32'(bus.pc_load), 32'(pops_pc));
        if (pops_pc) chk("end.pc_out", bus.pc_out, exp_pc);
        chk("end.sr_load", 32'(bus.sr_load), 0);
        chk("end.depth", 32'(bus.depth), 32'(ref_stk.size()));
        chk("end.ovf", 32'(bus.overflow), 32'(ref_ovf));
        chk("end.unf", 32'(bus.underflow), 32'(ref_unf));
    endtask

    initial begin
        bus.call_req = 0; bus.ret_req = 0; bus.int_req = 0; bus.reti_req = 0;
        bus.pc_in = '0; bus.sr_in = '0; bus.err_clr = 0;
        ref_ovf = 0; ref_unf = 0;

        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;

        run_op(R_CALL, 32'h100, 32'h0, 0);
        run_op(R_INT, 32'h200, 32'h5, 0);
        run_op(R_RETI, 32'h0, 32'h0, 0);
        run_op(R_CALL | R_RET, 32'h300, 32'h0, 0);
        run_op(R_INT | R_CALL, 32'h400, 32'h9, 0);
        run_op(R_RETI | R_CALL | R_RET, 32'h0, 32'h0, 0);

        for (int i = 0; i < 17; i++) run_op(R_CALL, 32'h1000 + 32'(i), 32'h0, 0);
        chk("sat.depth", 32'(bus.depth), D);
        chk("sat.ovf", 32'(bus.overflow), 1);
        clr_err();

        for (int i = 0; i < D; i++) run_op(R_RET, 32'h0, 32'h0, 0);
        run_op(R_RET, 32'h0, 32'h0, 0);
        chk("empty.pc_out", bus.pc_out, 0);
        chk("empty.unf", 32'(bus.underflow), 1);
        chk("empty.depth", 32'(bus.depth), 0);
        clr_err();

        for (int i = 0; i < D; i++) run_op(R_CALL, 32'h2000 + 32'(i), 32'h0, 0);
        run_op(R_CALL, 32'h2fff, 32'h0, 1);
        chk("setwins.ovf", 32'(bus.overflow), 1);
        clr_err();

        // Asynchronous reset in the middle of an INT sequence
        wait_ready();
        bus.int_req = 1'b1;
        bus.pc_in = 32'h500;
        bus.sr_in = 32'h7;
        @(posedge clk);
        @(negedge clk);
        bus.int_req = 1'b0;
        @(negedge clk);
        chk("midrst.push_sr", bus.stack_d, 32'h7);
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        reset = 1'b1;
        ref_stk.delete();
        ref_ovf = 0;
        ref_unf = 0;
        run_op(R_CALL, 32'h600, 32'h0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(1, 15));
            run_op(r, $urandom, $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
